// File: rtl/ccff_chain_programmer_if.sv
// Host-side handshake bundle for the configuration-chain programmer:
// operation request, load-word stream and readback-word stream.
interface ccff_chain_programmer_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              mode;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, cfg_data, cfg_valid, rd_ready,
    input  cfg_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  start, mode, cfg_data, cfg_valid, rd_ready,
    output cfg_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/ccff_chain_programmer.sv
// Serial configuration-chain master: loads host words MSB-first onto ccff_head
// and reads the chain back non-destructively by recirculating ccff_tail.
//
// state  | meaning
// IDLE   | waiting for start; samples mode
// FETCH  | cfg_ready high, waiting for a load word
// LSHIFT | shifting the held word into the chain, MSB first
// RSHIFT | recirculating tail to head while capturing tail bits
// PUSH   | rd_valid high, holding a captured word until rd_ready
// DONE   | one-cycle done pulse, then IDLE
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  ccff_chain_programmer_if.slave   host,
  output logic                     ccff_head,
  input  logic                     ccff_tail,
  output logic                     shift_en
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam int PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LSHIFT, RSHIFT, PUSH, DONE} state_t;

  state_t            state;
  logic [BW-1:0]     bits_left;
  logic [WW-1:0]     word_cnt;
  logic [PW-1:0]     cap_pos;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] cap;
  logic [WORD_W-1:0] cap_next;
  logic              head_q;
  logic              recirc;

  // Bits to move in the next word: a full word, or whatever is left of the chain.
  function automatic logic [WW-1:0] word_len(input logic [BW-1:0] left);
    if (int'(left) > WORD_W) return WW'(WORD_W);
    else                     return WW'(left);
  endfunction

  // Readback must present the pre-edge tail on the head, so recirculation is a mux.
  assign ccff_head = recirc ? ccff_tail : head_q;

  // Captured bits fill from the MSB down, leaving unused low bits at zero.
  assign cap_next  = cap | (WORD_W'(ccff_tail) << cap_pos);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state          <= IDLE;
      bits_left      <= '0;
      word_cnt       <= '0;
      cap_pos        <= '0;
      sreg           <= '0;
      cap            <= '0;
      head_q         <= 1'b0;
      recirc         <= 1'b0;
      shift_en       <= 1'b0;
      host.cfg_ready <= 1'b0;
      host.rd_valid  <= 1'b0;
      host.rd_data   <= '0;
      host.busy      <= 1'b0;
      host.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            host.busy <= 1'b1;
            bits_left <= BW'(CHAIN_LEN);
            if (!host.mode) begin
              state          <= FETCH;
              host.cfg_ready <= 1'b1;
            end else begin
              state    <= RSHIFT;
              shift_en <= 1'b1;
              recirc   <= 1'b1;
              word_cnt <= word_len(BW'(CHAIN_LEN));
              cap      <= '0;
              cap_pos  <= PW'(WORD_W - 1);
            end
          end
        end
        FETCH: begin
          if (host.cfg_valid) begin
            state          <= LSHIFT;
            host.cfg_ready <= 1'b0;
            shift_en       <= 1'b1;
            head_q         <= host.cfg_data[WORD_W-1];
            sreg           <= host.cfg_data << 1;
            word_cnt       <= word_len(bits_left);
          end
        end
        LSHIFT: begin
          head_q    <= sreg[WORD_W-1];
          sreg      <= sreg << 1;
          bits_left <= bits_left - BW'(1);
          word_cnt  <= word_cnt - WW'(1);
          if (word_cnt == WW'(1)) begin
            shift_en <= 1'b0;
            head_q   <= 1'b0;
            if (bits_left == BW'(1)) begin
              state     <= DONE;
              host.done <= 1'b1;
            end else begin
              state          <= FETCH;
              host.cfg_ready <= 1'b1;
            end
          end
        end
        RSHIFT: begin
          cap       <= cap_next;
          cap_pos   <= cap_pos - PW'(1);
          bits_left <= bits_left - BW'(1);
          word_cnt  <= word_cnt - WW'(1);
          if (word_cnt == WW'(1)) begin
            state         <= PUSH;
            shift_en      <= 1'b0;
            recirc        <= 1'b0;
            host.rd_valid <= 1'b1;
            host.rd_data  <= cap_next;
          end
        end
        PUSH: begin
          if (host.rd_ready) begin
            host.rd_valid <= 1'b0;
            if (bits_left == BW'(0)) begin
              state     <= DONE;
              host.done <= 1'b1;
            end else begin
              state    <= RSHIFT;
              shift_en <= 1'b1;
              recirc   <= 1'b1;
              word_cnt <= word_len(bits_left);
              cap      <= '0;
              cap_pos  <= PW'(WORD_W - 1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          host.done <= 1'b0;
          host.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Directed bench: two programmers (8-bit and 12-bit chains) driving behavioural
// chain models, with hand-computed expected head streams and readback words.
module tb_ccff_chain_programmer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccff_chain_programmer_if #(.WORD_W(8)) bus_a ();
  ccff_chain_programmer_if #(.WORD_W(8)) bus_b ();

  logic head_a, tail_a, sen_a;
  logic head_b, tail_b, sen_b;

  ccff_chain_programmer #(.CHAIN_LEN(8), .WORD_W(8)) dut_a (
    .prog_clk (clk),
    .pReset   (rst),
    .host     (bus_a),
    .ccff_head(head_a),
    .ccff_tail(tail_a),
    .shift_en (sen_a)
  );

  ccff_chain_programmer #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk (clk),
    .pReset   (rst),
    .host     (bus_b),
    .ccff_head(head_b),
    .ccff_tail(tail_b),
    .shift_en (sen_b)
  );

  // Chain models: index 0 sits next to ccff_head, MSB drives ccff_tail.
  logic [7:0]  chain_a  = '0;
  logic [11:0] chain_b  = '0;
  logic [31:0] hist_a   = '0;
  logic [31:0] hist_b   = '0;
  int          shifts_a = 0;
  int          shifts_b = 0;
  int          dones_a  = 0;

  assign tail_a = chain_a[7];
  assign tail_b = chain_b[11];

  always @(posedge clk) begin
    if (sen_a) begin
      chain_a  <= {chain_a[6:0], head_a};
      hist_a   <= {hist_a[30:0], head_a};
      shifts_a <= shifts_a + 1;
    end
    if (sen_b) begin
      chain_b  <= {chain_b[10:0], head_b};
      hist_b   <= {hist_b[30:0], head_b};
      shifts_b <= shifts_b + 1;
    end
    if (bus_a.done) dones_a <= dones_a + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s;
  int d;

  initial begin
    rst = 1'b1;
    bus_a.start = 0; bus_a.mode = 0; bus_a.cfg_data = '0; bus_a.cfg_valid = 0; bus_a.rd_ready = 0;
    bus_b.start = 0; bus_b.mode = 0; bus_b.cfg_data = '0; bus_b.cfg_valid = 0; bus_b.rd_ready = 0;
    repeat (2) tick();
    check("rst_outs_a", {bus_a.cfg_ready, bus_a.rd_valid, head_a, sen_a, bus_a.busy, bus_a.done}, 0);
    check("rst_rdata_a", bus_a.rd_data, 0);
    check("rst_outs_b", {bus_b.cfg_ready, bus_b.rd_valid, head_b, sen_b, bus_b.busy, bus_b.done}, 0);
    rst = 1'b0;
    tick();

    // Load A5 into the 8-bit chain
    s = shifts_a;
    bus_a.start = 1; bus_a.mode = 0; bus_a.cfg_data = 8'hA5; bus_a.cfg_valid = 1;
    tick();
    bus_a.start = 0;
    check("ld_fetch", {bus_a.cfg_ready, bus_a.busy, sen_a}, 3'b110);
    tick();
    check("ld_accept", {bus_a.cfg_ready, sen_a}, 2'b01);
    repeat (8) tick();
    check("ld_done", {bus_a.done, sen_a}, 2'b10);
    check("ld_nshift", shifts_a - s, 8);
    check("ld_heads", hist_a[7:0], 8'hA5);
    check("ld_chain", chain_a, 8'hA5);
    bus_a.cfg_valid = 0;
    tick();
    check("ld_idle", {bus_a.busy, bus_a.done, bus_a.cfg_ready}, 0);

    // Readback with a 3-cycle rd_ready stall
    s = shifts_a;
    bus_a.start = 1; bus_a.mode = 1; bus_a.rd_ready = 0;
    tick();
    bus_a.start = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.rd_valid) break;
      tick();
    end
    check("rb_valid", bus_a.rd_valid, 1);
    check("rb_data", bus_a.rd_data, 8'hA5);
    check("rb_nshift", shifts_a - s, 8);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rb_stall", {bus_a.rd_valid, sen_a, bus_a.rd_data}, {1'b1, 1'b0, 8'hA5});
    end
    check("rb_stall_nshift", shifts_a - s, 8);
    bus_a.rd_ready = 1;
    tick();
    bus_a.rd_ready = 0;
    check("rb_done", {bus_a.done, bus_a.rd_valid}, 2'b10);
    check("rb_chain", chain_a, 8'hA5);
    tick();

    // FETCH stall of 5 cycles, then a start pulse while busy
    s = shifts_a;
    bus_a.start = 1; bus_a.mode = 0; bus_a.cfg_data = 8'h5A; bus_a.cfg_valid = 0;
    tick();
    bus_a.start = 0;
    for (int k = 0; k < 5; k++) begin
      check("fetch_stall", {sen_a, bus_a.cfg_ready}, 2'b01);
      tick();
    end
    bus_a.cfg_valid = 1;
    tick();
    bus_a.cfg_valid = 0;
    bus_a.start = 1; bus_a.mode = 1;
    tick();
    bus_a.start = 0; bus_a.mode = 0;
    check("busy_start", {sen_a, bus_a.cfg_ready}, 2'b10);
    for (int k = 0; k < 40; k++) begin
      if (bus_a.done) break;
      tick();
    end
    check("busy_done", bus_a.done, 1);
    check("busy_nshift", shifts_a - s, 8);
    check("busy_chain", chain_a, 8'h5A);
    tick();
    tick();
    check("busy_no_restart", {bus_a.busy, sen_a}, 0);

    // Reset after 3 shifted bits, then a clean reload
    d = dones_a;
    bus_a.start = 1; bus_a.mode = 0; bus_a.cfg_data = 8'hFF; bus_a.cfg_valid = 1;
    tick();
    bus_a.start = 0;
    tick();
    bus_a.cfg_valid = 0;
    s = shifts_a;
    repeat (3) tick();
    check("mid_nshift", shifts_a - s, 3);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_outs", {bus_a.cfg_ready, bus_a.rd_valid, head_a, sen_a, bus_a.busy, bus_a.done}, 0);
    repeat (3) tick();
    check("mid_no_done", dones_a - d, 0);
    bus_a.start = 1; bus_a.mode = 0; bus_a.cfg_data = 8'h3C; bus_a.cfg_valid = 1;
    tick();
    bus_a.start = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.done) break;
      tick();
    end
    bus_a.cfg_valid = 0;
    check("mid_reload_done", bus_a.done, 1);
    check("mid_reload_chain", chain_a, 8'h3C);
    tick();

    // 12-bit chain: 3C then F0, low nibble of F0 dropped
    s = shifts_b;
    bus_b.start = 1; bus_b.mode = 0; bus_b.cfg_data = 8'h3C; bus_b.cfg_valid = 1;
    tick();
    bus_b.start = 0;
    tick();
    bus_b.cfg_data = 8'hF0;
    for (int k = 0; k < 60; k++) begin
      if (bus_b.done) break;
      tick();
    end
    bus_b.cfg_valid = 0;
    check("part_done", bus_b.done, 1);
    check("part_nshift", shifts_b - s, 12);
    check("part_heads", hist_b[11:0], 12'h3CF);
    check("part_chain", chain_b, 12'h3CF);
    tick();

    s = shifts_b;
    bus_b.start = 1; bus_b.mode = 1; bus_b.rd_ready = 1;
    tick();
    bus_b.start = 0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 40; k++) begin
        if (bus_b.rd_valid) break;
        tick();
      end
      check("part_rd_valid", bus_b.rd_valid, 1);
      check("part_rd_word", bus_b.rd_data, (w == 0) ? 32'h3C : 32'hF0);
      tick();
    end
    bus_b.rd_ready = 0;
    check("part_rd_done", bus_b.done, 1);
    check("part_rd_nshift", shifts_b - s, 12);
    check("part_rd_chain", chain_b, 12'h3CF);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
